// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice plus a carry register, LSB first, start/busy/done handshake.
// Optional OVERFLOW_EN macro adds a registered signed-overflow flag (ovf) held with sum/cout.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b;
  logic             carry;
  logic [CW-1:0]    count;

  logic load;
  logic run;
  logic last_bit;
  logic slice_sum;
  logic slice_cout;

  // A start is only honoured when no add is in flight.
  assign load     = start && (state != S_RUN);
  assign run      = (state == S_RUN);
  assign last_bit = run && (count == LAST);

  // Single full-adder slice operating on the current LSBs.
  always_comb begin
    slice_sum  = op_a[0] ^ op_b[0] ^ carry;
    slice_cout = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (count == LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // NOTE: every datapath register is reset, including the operand shifters, so the block starts fully defined.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef OVERFLOW_EN
      ovf   <= 1'b0;
`endif
    end else if (load) begin
      op_a  <= a;
      op_b  <= b;
      carry <= cin;
      count <= '0;
`ifdef OVERFLOW_EN
      ovf   <= 1'b0;
`endif
    end else if (run) begin
      sum   <= {slice_sum, sum[WIDTH-1:1]};
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      carry <= slice_cout;
      count <= count + CW'(1);
      if (last_bit) begin
        cout <= slice_cout;
`ifdef OVERFLOW_EN
        // Carry into the MSB differs from carry out exactly on signed overflow.
        ovf  <= carry ^ slice_cout;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: arithmetic reference model compared every cycle plus directed literal checks.
// An 8-bit instance runs the directed scenarios; a 2-bit instance is swept exhaustively.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef OVERFLOW_EN
  logic         ovf;
`endif

  logic       start2, cin2;
  logic [1:0] a2, b2;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;
`ifdef OVERFLOW_EN
  logic       ovf2;
`endif

  serial_adder #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  serial_adder #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
`ifdef OVERFLOW_EN
    , .ovf(ovf2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state for the 8-bit instance.
  logic         m_busy, m_done, m_cout, m_ovf;
  logic [W-1:0] m_sum;
  int           m_left;
  logic [W-1:0] p_sum;
  logic         p_cout, p_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Result of an add is plain integer arithmetic; latency is W edges after the load edge.
  task automatic model_step();
    int total, sa, sb, st;
    if (rst) begin
      m_busy = 0; m_done = 0; m_sum = '0; m_cout = 0; m_ovf = 0; m_left = 0;
    end else if (start && !m_busy) begin
      total  = int'(a) + int'(b) + int'(cin);
      p_sum  = W'(total);
      p_cout = (total > 255);
      sa     = int'($signed(a));
      sb     = int'($signed(b));
      st     = sa + sb + int'(cin);
      p_ovf  = (st > 127) || (st < -128);
      m_busy = 1; m_done = 0; m_ovf = 0; m_left = W;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1; m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
      end
    end else begin
      m_done = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    if (!m_busy) begin
      check("sum", 32'(sum), 32'(m_sum));
      check("cout", 32'(cout), 32'(m_cout));
`ifdef OVERFLOW_EN
      check("ovf", 32'(ovf), 32'(m_ovf));
`endif
    end
  endtask

  // Count edges (starting at first_k) until done rises; expect it on edge W.
  task automatic wait_done(input string tag, input int first_k);
    int lat;
    lat = 0;
    for (int k = first_k; k <= 20; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(W));
  endtask

  task automatic do_add(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc, input string tag);
    a = xa; b = xb; cin = xc; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(tag, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    tick();

    // Basic add, then carry-out cases.
    do_add(8'h0F, 8'h01, 1'b0, "t1");
    check("t1_sum", 32'(sum), 32'h10);
    check("t1_cout", 32'(cout), 32'd0);
    tick();
    do_add(8'hFF, 8'h01, 1'b0, "t2a");
    check("t2a_sum", 32'(sum), 32'h00);
    check("t2a_cout", 32'(cout), 32'd1);
    tick();
    do_add(8'hFF, 8'hFF, 1'b1, "t2b");
    check("t2b_sum", 32'(sum), 32'hFF);
    check("t2b_cout", 32'(cout), 32'd1);
    tick();
    check("t2b_idle_hold", 32'(sum), 32'hFF);

    // start during RUN must be ignored, operand changes too.
    a = 8'h05; b = 8'h03; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'hAA; start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_busy_mid", 32'(busy), 32'd1);
    wait_done("t3", 4);
    check("t3_sum", 32'(sum), 32'h08);
    check("t3_cout", 32'(cout), 32'd0);
    tick();
    check("t3_busy_after", 32'(busy), 32'd0);

    // Reset in the middle of an add aborts it with no done pulse.
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check("t4_sum", 32'(sum), 32'd0);
    check("t4_cout", 32'(cout), 32'd0);
    repeat (10) tick();
    do_add(8'h01, 8'h01, 1'b0, "t4b");
    check("t4b_sum", 32'(sum), 32'h02);

    // Back-to-back: new start accepted in the DONE cycle.
    a = 8'h3C; b = 8'h44; cin = 1'b1; start = 1'b1;
    tick();
    check("t5_load_done", 32'(done), 32'd0);
    check("t5_load_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done("t5a", 1);
    check("t5a_sum", 32'(sum), 32'h81);
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    tick();
    check("t5b_done_drop", 32'(done), 32'd0);
    check("t5b_busy_rise", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done("t5b", 1);
    check("t5b_sum", 32'(sum), 32'h00);
    check("t5b_cout", 32'(cout), 32'd1);
    tick();

`ifdef OVERFLOW_EN
    do_add(8'h7F, 8'h01, 1'b0, "t6a");
    check("t6a_sum", 32'(sum), 32'h80);
    check("t6a_ovf", 32'(ovf), 32'd1);
    tick();
    do_add(8'hFF, 8'h01, 1'b0, "t6b");
    check("t6b_ovf", 32'(ovf), 32'd0);
    check("t6b_cout", 32'(cout), 32'd1);
    tick();
`endif

    // Exhaustive sweep of the 2-bit instance.
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          int lat2;
          a2 = 2'(ia); b2 = 2'(ib); cin2 = 1'(ic); start2 = 1'b1;
          tick();
          start2 = 1'b0;
          lat2 = 0;
          for (int k = 1; k <= 6; k++) begin
            tick();
            if (done2) begin
              lat2 = k;
              break;
            end
          end
          check("w2_latency", 32'(lat2), 32'd2);
          check("w2_result", 32'({cout2, sum2}), 32'(ia + ib + ic));
`ifdef OVERFLOW_EN
          begin
            int sa2, sb2, s2;
            sa2 = (ia > 1) ? ia - 4 : ia;
            sb2 = (ib > 1) ? ib - 4 : ib;
            s2  = sa2 + sb2 + ic;
            check("w2_ovf", 32'(ovf2), 32'((s2 > 1) || (s2 < -2)));
          end
`endif
          tick();
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
